// File: rtl/nios2os_led_sequencer.sv
// nios2os_led_sequencer: Avalon-MM LED controller with a manual DATA register
// and a 4-entry pattern sequencer (one-shot or loop) stepping at a programmable
// rate. Optional PWM dimming is compiled in when LED_SEQ_PWM_EN is defined.
module nios2os_led_sequencer #(
  parameter int                  LED_W      = 4,
  parameter int                  PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(5_000_000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [LED_W-1:0]    data_q;
  logic [LED_W-1:0]    pat_q   [4];
  logic [LED_W-1:0]    data_nxt;
  logic [LED_W-1:0]    pat_nxt [4];
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_last;
  logic [PERIOD_W-1:0] cnt_q;
  logic [1:0]          step_q;
  logic [1:0]          step_inc;
  logic                loop_q;
  logic                done_q;
  logic                busy;
  logic [31:0]         ctrl_rd;

  logic wr_en, wr_ctrl, wr_status, wr_period;
  logic do_start, do_stop, clr_done;

  // Only a handful of writedata bits land in registers; the rest are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == 3'd1);
  assign wr_status = wr_en && (address == 3'd2);
  assign wr_period = wr_en && (address == 3'd3);
  assign do_stop   = wr_ctrl & writedata[1];
  assign do_start  = wr_ctrl & writedata[0];
  assign clr_done  = wr_status & writedata[1];

  assign busy     = (state_q == S_RUN);
  assign step_inc = step_q + 2'd1;
  // A period of 0 behaves as 1, so the last tick index is 0 in both cases.
  assign period_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

`ifdef LED_SEQ_PWM_EN
  logic [7:0] duty_q;
  logic [7:0] pwm_cnt_q;

  // Duty register and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (wr_ctrl) duty_q <= writedata[15:8];
    end
  end

  assign ctrl_rd = {16'd0, duty_q, 5'd0, loop_q, 2'b00};

  // Gate the selected LED value with the PWM comparator; full duty never blanks.
  function automatic logic [LED_W-1:0] led_drive(input logic [LED_W-1:0] v);
    logic gate;
    gate = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
    return v & {LED_W{gate}};
  endfunction
`else
  assign ctrl_rd = {29'd0, loop_q, 2'b00};

  function automatic logic [LED_W-1:0] led_drive(input logic [LED_W-1:0] v);
    return v;
  endfunction
`endif

  // Next values of DATA and the pattern table; out_port is loaded from these so
  // a write shows on the LEDs one cycle after the bus write.
  always_comb begin
    data_nxt = (wr_en && (address == 3'd0)) ? writedata[LED_W-1:0] : data_q;
    for (int i = 0; i < 4; i++) begin
      pat_nxt[i] = (wr_en && (address == 3'(4 + i))) ? writedata[LED_W-1:0] : pat_q[i];
    end
  end

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      pat_q    <= '{default: '0};
      period_q <= PERIOD_RST;
      loop_q   <= 1'b0;
    end else begin
      data_q <= data_nxt;
      pat_q  <= pat_nxt;
      if (wr_period) period_q <= writedata[PERIOD_W-1:0];
      if (wr_ctrl)   loop_q   <= writedata[2];
    end
  end

  // Sequencer FSM with registered LED output; STOP beats START, DONE set beats W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      out_port <= '0;
    end else begin
      if (clr_done) done_q <= 1'b0;
      if (do_stop) begin
        state_q  <= S_IDLE;
        out_port <= led_drive(data_nxt);
      end else if (do_start) begin
        state_q  <= S_RUN;
        step_q   <= 2'd0;
        cnt_q    <= '0;
        done_q   <= 1'b0;
        out_port <= led_drive(pat_nxt[0]);
      end else begin
        case (state_q)
          S_IDLE: begin
            out_port <= led_drive(data_nxt);
          end
          S_RUN: begin
            if (cnt_q == period_last) begin
              cnt_q <= '0;
              if (step_q != 2'd3) begin
                step_q   <= step_inc;
                out_port <= led_drive(pat_nxt[step_inc]);
              end else if (loop_q) begin
                step_q   <= 2'd0;
                out_port <= led_drive(pat_nxt[0]);
              end else begin
                state_q  <= S_DONE;
                out_port <= led_drive(pat_nxt[3]);
              end
            end else begin
              cnt_q    <= cnt_q + PERIOD_W'(1);
              out_port <= led_drive(pat_nxt[step_q]);
            end
          end
          S_DONE: begin
            state_q  <= S_IDLE;
            done_q   <= 1'b1;
            out_port <= led_drive(data_nxt);
          end
          default: begin
            state_q  <= S_IDLE;
            out_port <= led_drive(data_nxt);
          end
        endcase
      end
    end
  end

  // Zero-latency register readback.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(data_q);
      3'd1:    readdata = ctrl_rd;
      3'd2:    readdata = {26'd0, step_q, 2'b00, done_q, busy};
      3'd3:    readdata = 32'(period_q);
      default: readdata = 32'(pat_q[address[1:0]]);
    endcase
  end

endmodule

// File: tb/tb_nios2os_led_sequencer.sv
`timescale 1ns/1ps
module tb_nios2os_led_sequencer;

  localparam int LED_W = 4;
`ifdef LED_SEQ_PWM_EN
  localparam logic [31:0] CTRL_RST = 32'h0000_FF00;
  localparam logic [31:0] CTRL_RB  = 32'h0000_FF04;
`else
  localparam logic [31:0] CTRL_RST = 32'h0;
  localparam logic [31:0] CTRL_RB  = 32'h0000_0004;
`endif
  // Duty bits kept at full scale in every CTRL write so PWM builds stay ungated.
  localparam logic [31:0] CTRL_BASE = 32'h0000_FF00;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [LED_W-1:0] out_port;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2os_led_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  // LED value k cycles after the start write (k=0 is the first running cycle).
  function automatic logic [3:0] model_out(input int k, input int p, input bit loop,
                                            input int stop_k, input logic [3:0] pat[4],
                                            input logic [3:0] dat);
    int pp;
    pp = (p == 0) ? 1 : p;
    if (k > stop_k) return dat;
    if (loop) return pat[(k / pp) % 4];
    if (k < 4 * pp) return pat[k / pp];
    if (k == 4 * pp) return pat[3];
    return dat;
  endfunction

  task automatic run_trial(input int p, input bit loop, input int stop_k, input int len,
                           input logic [3:0] pat[4], input logic [3:0] dat);
    logic [31:0] st;
    int pp;
    bit stopped;
    logic [31:0] exp_st;
    pp = (p == 0) ? 1 : p;
    bus_wr(3'd0, 32'(dat));
    bus_wr(3'd3, 32'(p));
    for (int i = 0; i < 4; i++) bus_wr(3'(4 + i), 32'(pat[i]));
    bus_wr(3'd1, CTRL_BASE | {29'd0, loop, 2'b01});
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      #1;
      check($sformatf("rand_out p=%0d loop=%0d k=%0d", p, loop, k), 32'(out_port),
            32'(model_out(k, p, loop, stop_k, pat, dat)));
      if (k == stop_k) begin
        address = 3'd1; writedata = CTRL_BASE | 32'h2; chipselect = 1'b1; write_n = 1'b0;
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    stopped = loop || (stop_k < 4 * pp);
    if (stopped) exp_st = 32'(((stop_k / pp) % 4) << 4);
    else         exp_st = 32'h32;
    bus_rd(3'd2, st);
    check("rand_status", st, exp_st);
    bus_wr(3'd2, 32'h2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] rd;
    logic [31:0] rst_exp[8];
    logic [3:0]  exp_seq[14];
    logic [3:0]  exp_loop[6];
    logic [3:0]  pat[4];
    int          cnt;

    vecs[0] = '{3'd0, 32'hFFFF_FFFA, 32'h0000_000A,   4'hA};
    vecs[1] = '{3'd3, 32'hFFFF_FFFF, 32'h00FF_FFFF,   4'hA};
    vecs[2] = '{3'd3, 32'h0000_0000, 32'h0000_0000,   4'hA};
    vecs[3] = '{3'd4, 32'h0000_0035, 32'h0000_0005,   4'hA};
    vecs[4] = '{3'd7, 32'hFFFF_FF3C, 32'h0000_000C,   4'hA};
    vecs[5] = '{3'd1, 32'h0000_FF06, CTRL_RB,         4'hA};
    vecs[6] = '{3'd1, 32'h0000_FF00, CTRL_RST,        4'hA};
    vecs[7] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0000,   4'hA};
    vecs[8] = '{3'd0, 32'h0000_0003, 32'h0000_0003,   4'h3};

    rst_exp  = '{32'h0, CTRL_RST, 32'h0, 32'd5_000_000, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_seq  = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                 4'h8, 4'h8, 4'h8, 4'h8, 4'hA};
    exp_loop = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_out", 32'(out_port), 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), rd);
      check($sformatf("reset_rd a=%0d", a), rd, rst_exp[a]);
    end

    // Register write/readback table.
    for (int i = 0; i < 9; i++) begin
      bus_wr(vecs[i].addr, vecs[i].wdata);
      bus_rd(vecs[i].addr, rd);
      check($sformatf("vec_rd %0d", i), rd, vecs[i].exp_rd);
      check($sformatf("vec_out %0d", i), 32'(out_port), 32'(vecs[i].exp_out));
    end

    // One-shot, PERIOD=3, pattern 1,2,4,8.
    bus_wr(3'd0, 32'hA);
    bus_wr(3'd3, 32'd3);
    bus_wr(3'd4, 32'h1); bus_wr(3'd5, 32'h2); bus_wr(3'd6, 32'h4); bus_wr(3'd7, 32'h8);
    bus_wr(3'd1, CTRL_BASE | 32'h1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      address = 3'd2;
      #1;
      check($sformatf("oneshot_out k=%0d", k), 32'(out_port), 32'(exp_seq[k]));
      if (k == 0) check("oneshot_busy", 32'(readdata[0]), 32'h1);
    end
    bus_rd(3'd2, rd);
    check("oneshot_done", 32'(rd[1:0]), 32'h2);
    check("oneshot_step", 32'(rd[5:4]), 32'h3);
    bus_wr(3'd2, 32'h2);
    bus_rd(3'd2, rd);
    check("w1c_done", 32'(rd[1:0]), 32'h0);

    // Loop mode with PERIOD=0, then STOP.
    bus_wr(3'd0, 32'h5);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd1, CTRL_BASE | 32'h5);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("loop_out k=%0d", k), 32'(out_port), 32'(exp_loop[k]));
    end
    bus_wr(3'd1, CTRL_BASE | 32'h2);
    @(negedge clk);
    address = 3'd2;
    #1;
    check("stop_out", 32'(out_port), 32'h5);
    check("stop_busy_done", 32'(readdata[1:0]), 32'h0);

    // START and STOP together: stays idle.
    bus_wr(3'd1, CTRL_BASE | 32'h3);
    bus_rd(3'd2, rd);
    check("startstop_busy", 32'(rd[1:0]), 32'h0);
    check("startstop_out", 32'(out_port), 32'h5);

    // Reset in the middle of step 2.
    bus_wr(3'd3, 32'd3);
    bus_wr(3'd1, CTRL_BASE | 32'h1);
    for (int k = 0; k < 7; k++) @(negedge clk);
    #1;
    check("pre_reset_out", 32'(out_port), 32'h4);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    address = 3'd2;
    #1;
    check("midreset_out", 32'(out_port), 32'h0);
    check("midreset_status", readdata, 32'h0);
    address = 3'd3;
    #1;
    check("midreset_period", readdata, 32'd5_000_000);
    reset = 1'b0;

    // Randomized sequences against the reference model.
    for (int t = 0; t < 30; t++) begin
      int  p, pp, stop_k, len;
      bit  loop;
      logic [3:0] dat;
      p    = $urandom_range(0, 5);
      pp   = (p == 0) ? 1 : p;
      loop = 1'($urandom_range(0, 1));
      dat  = 4'($urandom);
      for (int i = 0; i < 4; i++) pat[i] = 4'($urandom);
      if (loop) stop_k = $urandom_range(0, 12 * pp);
      else if ($urandom_range(0, 1) == 1) stop_k = $urandom_range(0, 4 * pp - 1);
      else stop_k = 1000;
      if (loop || stop_k < 4 * pp) len = stop_k + 3;
      else len = 4 * pp + 4;
      run_trial(p, loop, stop_k, len, pat, dat);
    end

`ifdef LED_SEQ_PWM_EN
    // PWM duty cycles.
    bus_wr(3'd0, 32'hF);
    bus_wr(3'd1, 32'(64 << 8));
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (out_port == 4'hF) cnt++;
    end
    check("pwm_duty64", 32'(cnt), 32'd64);
    bus_wr(3'd1, 32'h0);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (out_port == 4'hF) cnt++;
    end
    check("pwm_duty0", 32'(cnt), 32'd0);
    bus_wr(3'd1, 32'h0000_FF00);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (out_port == 4'hF) cnt++;
    end
    check("pwm_duty255", 32'(cnt), 32'd256);
`else
    cnt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
